// File: rtl/serial_loader_if.sv
// ----------------------------------------------------------------------------
// serial_loader_if -- word handshake between serial_loader and its consumer.
//
//   word_valid  producer -> consumer  assembled word pair is presented
//   word_ready  consumer -> producer  consumer accepts the presented word
//   word_addr   producer -> consumer  0-based word index (ADDR_W bits)
//   pix_word    producer -> consumer  assembled pixel byte
//   wgt_word    producer -> consumer  assembled weight byte
//
// A transfer happens on a rising clock edge with word_valid && word_ready.
// ----------------------------------------------------------------------------
interface serial_loader_if #(
    parameter int ADDR_W = 7
);
    logic              word_valid;
    logic              word_ready;
    logic [ADDR_W-1:0] word_addr;
    logic [7:0]        pix_word;
    logic [7:0]        wgt_word;

    modport master (
        output word_valid,
        output word_addr,
        output pix_word,
        output wgt_word,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_addr,
        input  pix_word,
        input  wgt_word,
        output word_ready
    );
endinterface

// File: rtl/serial_loader.sv
// ----------------------------------------------------------------------------
// serial_loader -- assembles a serial stream of (pixel, weight) bit pairs into
// byte-wide words and hands them to a consumer over a valid/ready interface.
//
// Ports:
//   clk, reset_n       single clock, asynchronous active-low reset
//   sync_in_p/w        synchronized pixel / weight bit
//   sync_in_en         synchronized load strobe; each rising edge = one pair
//   wb (master)        word_valid/word_ready/word_addr/pix_word/wgt_word
//   done               high once all TOTAL_BITS pairs are in and the final
//                      word has left the output register
//   overrun            sticky: a completed word was dropped because the
//                      previous one was still waiting
//   match_cnt          XNOR popcount of accepted pairs
//
// Build option: define LOADER_XNOR_CNT_EN to build the match counter;
// otherwise match_cnt is tied to 0.
// ----------------------------------------------------------------------------
module serial_loader #(
    parameter int TOTAL_BITS = 784,
    parameter int ADDR_W     = 7
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sync_in_p,
    input  logic            sync_in_w,
    input  logic            sync_in_en,
    serial_loader_if.master wb,
    output logic            done,
    output logic            overrun,
    output logic [9:0]      match_cnt
);

    // Bit counter must hold TOTAL_BITS-1 and expose a 3-bit in-word position.
    localparam int CNT_W = ($clog2(TOTAL_BITS + 1) < 3) ? 3 : $clog2(TOTAL_BITS + 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              en_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic [7:0]        pix_sr, wgt_sr;
    logic [ADDR_W-1:0] wr_idx;
    logic              valid_q;
    logic [7:0]        pix_q, wgt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              overrun_q;

    logic              strobe, take, last_bit, word_done, xfer, can_load;
    logic [7:0]        pix_nxt, wgt_nxt;
    logic [2:0]        algn_sh;

    // Rising-edge detect on the load strobe; data is sampled in the same cycle.
    assign strobe    = sync_in_en & ~en_q;
    assign take      = strobe && (state_q == ST_LOAD);
    assign pix_nxt   = {pix_sr[6:0], sync_in_p};
    assign wgt_nxt   = {wgt_sr[6:0], sync_in_w};
    assign last_bit  = (bit_cnt == CNT_W'(TOTAL_BITS - 1));
    assign word_done = take && ((bit_cnt[2:0] == 3'd7) || last_bit);
    assign xfer      = valid_q && wb.word_ready;
    assign can_load  = !valid_q || xfer;
    // A short final word holds its bits in the low end of the shift register;
    // shift them up so the word is left-aligned and zero-filled. For a full
    // word this is zero. Stale bits from the previous word fall off the top.
    assign algn_sh   = 3'd7 - bit_cnt[2:0];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_LOAD;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (take && last_bit) state_d = ST_DRAIN;
            ST_DRAIN: if (can_load)         state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;    // only reset leaves DONE
            default:  state_d = ST_LOAD;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q      <= 1'b0;
            bit_cnt   <= '0;
            pix_sr    <= '0;
            wgt_sr    <= '0;
            wr_idx    <= '0;
            valid_q   <= 1'b0;
            pix_q     <= '0;
            wgt_q     <= '0;
            addr_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            en_q <= sync_in_en;

            if (take) begin
                pix_sr  <= pix_nxt;
                wgt_sr  <= wgt_nxt;
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (word_done) begin
                // The write index advances even when the word is dropped so
                // later words keep their true position in the image.
                wr_idx <= wr_idx + ADDR_W'(1);
                if (can_load) begin
                    pix_q   <= pix_nxt << algn_sh;
                    wgt_q   <= wgt_nxt << algn_sh;
                    addr_q  <= wr_idx;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef LOADER_XNOR_CNT_EN
    logic [9:0] match_q;

    // Counts only pairs accepted in LOAD, so it freezes from DRAIN onward.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          match_q <= '0;
        else if (take && (sync_in_p == sync_in_w)) match_q <= match_q + 10'd1;
    end

    assign match_cnt = match_q;
`else
    assign match_cnt = '0;
`endif

    assign wb.word_valid = valid_q;
    assign wb.pix_word   = pix_q;
    assign wb.wgt_word   = wgt_q;
    assign wb.word_addr  = addr_q;
    assign done          = (state_q == ST_DONE);
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_serial_loader.sv
module tb_serial_loader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       p, w, en;
    logic       done_a, ovr_a, done_b, ovr_b;
    logic [9:0] mc_a, mc_b;

    serial_loader_if #(.ADDR_W(7)) bus_a ();
    serial_loader_if #(.ADDR_W(7)) bus_b ();

    always #5 clk = ~clk;

    serial_loader #(.TOTAL_BITS(784), .ADDR_W(7)) dut_a (
        .clk(clk), .reset_n(reset_n), .sync_in_p(p), .sync_in_w(w), .sync_in_en(en),
        .wb(bus_a), .done(done_a), .overrun(ovr_a), .match_cnt(mc_a)
    );

    serial_loader #(.TOTAL_BITS(12), .ADDR_W(7)) dut_b (
        .clk(clk), .reset_n(reset_n), .sync_in_p(p), .sync_in_w(w), .sync_in_en(en),
        .wb(bus_b), .done(done_b), .overrun(ovr_b), .match_cnt(mc_b)
    );

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] pix;
        logic [7:0] wgt;
    } word_t;

    typedef struct {
        logic [7:0] p_in;
        logic [7:0] w_in;
        logic [7:0] exp_pix;
        logic [7:0] exp_wgt;
        int         exp_match;
    } vec_t;

    word_t exp_q[$];
    word_t b_log[$];
    word_t mon_e;
    int    checks = 0;
    int    errors = 0;
    int    xfers  = 0;
    int    mc_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard for DUT A: every transfer pops and compares one expected word.
    always @(negedge clk) begin
        if (bus_a.word_valid === 1'b1 && bus_a.word_ready === 1'b1) begin
            xfers++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got addr %0d pix 0x%0h wgt 0x%0h, none expected",
                         bus_a.word_addr, bus_a.pix_word, bus_a.wgt_word);
            end else begin
                mon_e = exp_q.pop_front();
                check("word_addr", 32'(bus_a.word_addr), 32'(mon_e.addr));
                check("pix_word",  32'(bus_a.pix_word),  32'(mon_e.pix));
                check("wgt_word",  32'(bus_a.wgt_word),  32'(mon_e.wgt));
            end
        end
    end

    // DUT B transfers are logged and checked by hand.
    always @(negedge clk) begin
        if (bus_b.word_valid === 1'b1 && bus_b.word_ready === 1'b1)
            b_log.push_back({bus_b.word_addr, bus_b.pix_word, bus_b.wgt_word});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic pb, input logic wb_);
        p  = pb;
        w  = wb_;
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] pb, input logic [7:0] wb_);
        for (int i = 7; i >= 0; i--) strobe(pb[i], wb_[i]);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        b_log.delete();
        xfers  = 0;
        mc_exp = 0;
        #3;
        reset_n = 1'b1;
        tick();
    endtask

    function automatic logic [31:0] exp_mc(input int m);
`ifdef LOADER_XNOR_CNT_EN
        return 32'(m);
`else
        return 32'(m - m);
`endif
    endfunction

    vec_t       tbl[4];
    logic [7:0] bp, bw;

    initial begin
        reset_n = 1'b0;
        p = 1'b0; w = 1'b0; en = 1'b0;
        bus_a.word_ready = 1'b0;
        bus_b.word_ready = 1'b1;

        // Reset state (asynchronous, before any clock edge)
        #3;
        check("rst_valid",   32'(bus_a.word_valid), 32'd0);
        check("rst_pix",     32'(bus_a.pix_word),   32'd0);
        check("rst_addr",    32'(bus_a.word_addr),  32'd0);
        check("rst_done",    32'(done_a),           32'd0);
        check("rst_overrun", 32'(ovr_a),            32'd0);
        check("rst_match",   32'(mc_a),             32'd0);
        #9;
        reset_n = 1'b1;
        tick();

        // Table-driven words with the consumer always ready
        tbl[0] = '{8'hB2, 8'hFF, 8'hB2, 8'hFF, 4};
        tbl[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 8};
        tbl[2] = '{8'hA5, 8'h5A, 8'hA5, 8'h5A, 0};
        tbl[3] = '{8'h3C, 8'h33, 8'h3C, 8'h33, 4};
        bus_a.word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({7'(i), tbl[i].exp_pix, tbl[i].exp_wgt});
            send_byte(tbl[i].p_in, tbl[i].w_in);
            mc_exp += tbl[i].exp_match;
            check("tbl_match",   32'(mc_a),             exp_mc(mc_exp));
            check("tbl_overrun", 32'(ovr_a),            32'd0);
            check("tbl_valid",   32'(bus_a.word_valid), 32'd0);
        end
        check("tbl_xfers", 32'(xfers),        32'd4);
        check("tbl_queue", 32'(exp_q.size()), 32'd0);

        // Enable held high for 5 cycles captures only one pair
        do_reset();
        bus_a.word_ready = 1'b1;
        exp_q.push_back({7'd0, 8'h80, 8'h80});
        p = 1'b1; w = 1'b1; en = 1'b1;
        repeat (5) tick();
        en = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) strobe(1'b0, 1'b0);
        check("hold_xfers", 32'(xfers), 32'd1);
        check("hold_match", 32'(mc_a),  exp_mc(8));

        // Consumer stalled: second word dropped, first held stable
        do_reset();
        bus_a.word_ready = 1'b0;
        exp_q.push_back({7'd0, 8'hC3, 8'h3C});
        send_byte(8'hC3, 8'h3C);
        check("stall_valid",    32'(bus_a.word_valid), 32'd1);
        check("stall_addr",     32'(bus_a.word_addr),  32'd0);
        check("stall_pix",      32'(bus_a.pix_word),   32'hC3);
        check("stall_ovr0",     32'(ovr_a),            32'd0);
        send_byte(8'h11, 8'h22);
        check("drop_overrun",   32'(ovr_a),            32'd1);
        check("drop_valid",     32'(bus_a.word_valid), 32'd1);
        check("drop_pix_hold",  32'(bus_a.pix_word),   32'hC3);
        check("drop_wgt_hold",  32'(bus_a.wgt_word),   32'h3C);
        check("drop_addr_hold", 32'(bus_a.word_addr),  32'd0);
        bus_a.word_ready = 1'b1;
        tick();
        check("drain_valid", 32'(bus_a.word_valid), 32'd0);
        check("drain_xfers", 32'(xfers),            32'd1);
        exp_q.push_back({7'd2, 8'h6E, 8'h91});
        send_byte(8'h6E, 8'h91);
        check("after_drop_xfers", 32'(xfers), 32'd2);
        check("overrun_sticky",   32'(ovr_a), 32'd1);

        // Word completes on the same edge the pending word transfers
        do_reset();
        bus_a.word_ready = 1'b0;
        exp_q.push_back({7'd0, 8'h12, 8'h34});
        send_byte(8'h12, 8'h34);
        bp = 8'hAB;
        bw = 8'hCD;
        exp_q.push_back({7'd1, bp, bw});
        for (int i = 7; i >= 1; i--) strobe(bp[i], bw[i]);
        p = bp[0]; w = bw[0]; en = 1'b1;
        bus_a.word_ready = 1'b1;
        tick();
        check("coinc_valid",   32'(bus_a.word_valid), 32'd1);
        check("coinc_addr",    32'(bus_a.word_addr),  32'd1);
        check("coinc_pix",     32'(bus_a.pix_word),   32'hAB);
        check("coinc_overrun", 32'(ovr_a),            32'd0);
        check("coinc_xfers1",  32'(xfers),            32'd1);
        en = 1'b0;
        tick();
        check("coinc_xfers2", 32'(xfers),            32'd2);
        check("coinc_valid0", 32'(bus_a.word_valid), 32'd0);

        // Asynchronous reset mid-handshake and mid-word
        do_reset();
        bus_a.word_ready = 1'b0;
        send_byte(8'hFF, 8'hFF);
        check("pre_rst_valid", 32'(bus_a.word_valid), 32'd1);
        for (int i = 0; i < 5; i++) strobe(1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus_a.word_valid), 32'd0);
        check("mid_rst_pix",   32'(bus_a.pix_word),   32'd0);
        check("mid_rst_wgt",   32'(bus_a.wgt_word),   32'd0);
        check("mid_rst_addr",  32'(bus_a.word_addr),  32'd0);
        check("mid_rst_match", 32'(mc_a),             32'd0);
        exp_q.delete();
        xfers = 0;
        #1;
        reset_n = 1'b1;
        tick();
        bus_a.word_ready = 1'b1;
        exp_q.push_back({7'd0, 8'h5A, 8'h0F});
        send_byte(8'h5A, 8'h0F);
        check("post_rst_xfers", 32'(xfers),        32'd1);
        check("final_queue",    32'(exp_q.size()), 32'd0);

        // Short image (DUT B, 12 pairs): partial final word, DONE, ignored strobe
        do_reset();
        bus_a.word_ready = 1'b0;
        bus_b.word_ready = 1'b1;
        for (int i = 0; i < 11; i++) strobe(1'b1, 1'b0);
        p = 1'b1; w = 1'b0; en = 1'b1;
        tick();
        check("b_last_valid", 32'(bus_b.word_valid), 32'd1);
        check("b_last_pix",   32'(bus_b.pix_word),   32'hF0);
        check("b_last_addr",  32'(bus_b.word_addr),  32'd1);
        check("b_done_early", 32'(done_b),           32'd0);
        en = 1'b0;
        tick();
        check("b_done",      32'(done_b),           32'd1);
        check("b_valid0",    32'(bus_b.word_valid), 32'd0);
        check("b_log_size",  32'(b_log.size()),     32'd2);
        if (b_log.size() == 2) begin
            check("b_word0", 32'(b_log[0]), 32'({7'd0, 8'hFF, 8'h00}));
            check("b_word1", 32'(b_log[1]), 32'({7'd1, 8'hF0, 8'h00}));
        end
        strobe(1'b1, 1'b1);
        check("b_done_hold",  32'(done_b),           32'd1);
        check("b_ignored",    32'(b_log.size()),     32'd2);
        check("b_valid_hold", 32'(bus_b.word_valid), 32'd0);
        check("b_match_hold", 32'(mc_b),             32'd0);
        check("b_overrun",    32'(ovr_b),            32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_loader.md
SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001: Parameter TOTAL_BITS, default 784, SHALL set the number of bit-pairs per image (one pixel bit plus one weight bit each).
REQ-002: Parameter ADDR_W, default 7, SHALL set the width of word_addr and SHALL satisfy 2**ADDR_W >= ceil(TOTAL_BITS/8).
REQ-003: clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004: reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005: sync_in_p  in  1  SHALL be the synchronized pixel bit.
REQ-006: sync_in_w  in  1  SHALL be the synchronized weight bit.
REQ-007: sync_in_en  in  1  SHALL be the synchronized load strobe; each rising edge carries one bit-pair.
REQ-008: word_valid  out  1  SHALL indicate that an assembled word pair is presented.
REQ-009: word_ready  in  1  SHALL indicate that the consumer accepts the presented word.
REQ-010: word_addr  out  ADDR_W  SHALL give the word index (0-based) of the presented word.
REQ-011: pix_word  out  8  SHALL carry the assembled pixel byte.
REQ-012: wgt_word  out  8  SHALL carry the assembled weight byte.
REQ-013: done  out  1  SHALL be high once all TOTAL_BITS pairs are received and the final word is transferred.
REQ-014: overrun  out  1  SHALL be a sticky flag for a dropped word.
REQ-015: match_cnt  out  10  SHALL carry the XNOR popcount (see Configuration).

Function
REQ-016: Strobe SHALL be sync_in_en high while a registered copy of sync_in_en, reset to 0, is low; a single-cycle detect; sync_in_p/sync_in_w are sampled in that same cycle.
REQ-017: The FSM SHALL have states LOAD, DRAIN and DONE; reset enters LOAD.
REQ-018: In LOAD each strobe SHALL shift the pair into 8-bit pixel/weight shift registers MSB-first and increment an 8-bit-aligned bit counter.
REQ-019: On the 8th bit of a word, pix_word/wgt_word/word_addr SHALL load from the shift registers, and word_valid SHALL rise at that same clock edge.
REQ-020: A transfer SHALL occur on a rising edge with word_valid && word_ready; word_valid SHALL then drop unless a new word loads on the same edge.
REQ-021: While word_valid is high and untransferred, pix_word, wgt_word and word_addr SHALL remain stable.
REQ-022: If a word completes while word_valid is high and no transfer occurs on that edge, the new word SHALL be dropped, overrun SHALL set, and word_addr SHALL still advance for the next word.
REQ-023: A word completion coinciding with a transfer SHALL load the new word, with word_valid remaining high.
REQ-024: When the bit counter reaches TOTAL_BITS, a partial final word SHALL be emitted left-aligned with zero-filled low bits, and the FSM SHALL enter DRAIN.
REQ-025: DRAIN SHALL go to DONE on the edge where the output register is empty or transferred; done SHALL be high only in DONE.
REQ-026: Strobes in DRAIN or DONE SHALL be ignored; DONE SHALL be left only via reset.

Reset
REQ-027: Reset assertion SHALL asynchronously set word_valid=0, pix_word=0, wgt_word=0, word_addr=0, done=0, overrun=0 and match_cnt=0, clear the counters, shift registers and en history, and force LOAD, including mid-word and mid-handshake.

Configuration
REQ-028: With LOADER_XNOR_CNT_EN defined, match_cnt SHALL increment by 1 on every accepted strobe where sync_in_p == sync_in_w; it SHALL hold from DRAIN onward.
REQ-029: Without LOADER_XNOR_CNT_EN, match_cnt SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-030: 8 strobes, pixel bits 1,0,1,1,0,0,1,0 and weights all 1, word_ready=1 -> one word_valid pulse, pix_word=0xB2, wgt_word=0xFF, word_addr=0, match_cnt=4 with macro.
REQ-031: sync_in_en held high 5 cycles -> exactly one bit-pair captured.
REQ-032: word_ready=0, 16 strobes -> first word held stable at addr 0, overrun=1, second word dropped; word_ready=1 -> transfer, word_valid=0.
REQ-033: TOTAL_BITS=12, 12 strobes of p=1 -> words 0xFF@0 then 0xF0@1; done=1 after last transfer; 13th strobe ignored.
REQ-034: reset_n pulsed low after 5 strobes -> all outputs 0 immediately; 8 new strobes -> word at addr 0 with only post-reset bits.
REQ-035: Completion on same edge as transfer (word_ready=1 at 16th strobe, word 0 pending) -> word 1 presented, word_valid stays high, overrun=0.
